// File: rtl/uart_echo_fifo.sv
// Byte loopback between UART receiver and transmitter: words are buffered in a
// DEPTH-entry FIFO and re-issued with a runtime-selectable transform.
module uart_echo_fifo #(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned ADDEND       = 1,
    parameter int unsigned DROP_ON_FULL = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           rx_data,
    input  logic                       rx_flag,
    output logic                       rx_ack,
    output logic [WIDTH-1:0]           tx_data,
    input  logic                       tx_flag,
    output logic                       tx_wr,
    input  logic [1:0]                 mode,
    input  logic                       clr_ovf,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       ovf
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    localparam logic R_IDLE = 1'b0;
    localparam logic R_ACK  = 1'b1;
    localparam logic T_IDLE = 1'b0;
    localparam logic T_WR   = 1'b1;

    logic             rx_state_q, rx_state_d;
    logic             tx_state_q, tx_state_d;
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] tx_data_q, tx_data_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic full, accept, push, drop, pop;

    function automatic logic [WIDTH-1:0] transform(input logic [WIDTH-1:0] w,
                                                   input logic [1:0]       m);
        logic [31:0]      v;
        logic [WIDTH-1:0] r;
        v = 32'(w);
        r = w;
        case (m)
            2'd0: r = w;
            2'd1: r = w + WIDTH'(ADDEND);
            2'd2: r = ~w;
            default: begin
                // ASCII letters only; other widths pass through unchanged
                if (WIDTH == 8 && ((v >= 32'h41 && v <= 32'h5A) ||
                                   (v >= 32'h61 && v <= 32'h7A))) begin
                    r = w ^ WIDTH'(32'h20);
                end
            end
        endcase
        return r;
    endfunction

    assign full = (count_q == CW'(DEPTH));

    always_comb begin
        accept = 1'b0;
        push   = 1'b0;
        drop   = 1'b0;
        if (rx_state_q == R_IDLE && rx_flag) begin
            if (!full) begin
                accept = 1'b1;
                push   = 1'b1;
            end else if (DROP_ON_FULL != 0) begin
                accept = 1'b1;
                drop   = 1'b1;
            end
        end
        pop        = (tx_state_q == T_IDLE) && (count_q != '0) && tx_flag;
        rx_state_d = accept ? R_ACK : R_IDLE;
        tx_state_d = pop ? T_WR : T_IDLE;
        tx_data_d  = pop ? transform(mem_q[rd_ptr_q], mode) : tx_data_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // A drop in the same cycle as a clear keeps the flag set
        ovf_d = drop ? 1'b1 : (clr_ovf ? 1'b0 : ovf_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_state_q <= R_IDLE;
            tx_state_q <= T_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            tx_state_q <= tx_state_d;
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            tx_data_q  <= tx_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= rx_data;
    end

    assign rx_ack  = (rx_state_q == R_ACK);
    assign tx_wr   = (tx_state_q == T_WR);
    assign tx_data = tx_data_q;
    assign count   = count_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_uart_echo_fifo.sv
// Directed bench for uart_echo_fifo: stall-policy instance for echo, transform,
// fill/stall and async reset; drop-policy instance for fill/drop and ovf.
module tb_uart_echo_fifo;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data, d_rx_data;
    logic       rx_flag, d_rx_flag;
    logic       tx_flag, d_tx_flag;
    logic [1:0] mode, d_mode;
    logic       clr_ovf, d_clr_ovf;
    logic       rx_ack, d_rx_ack;
    logic       tx_wr, d_tx_wr;
    logic [7:0] tx_data, d_tx_data;
    logic [4:0] count, d_count;
    logic       ovf, d_ovf;

    int checks   = 0;
    int failures = 0;
    int got, acked, extra;

    always #5 clk = ~clk;

    uart_echo_fifo #(.WIDTH(8), .DEPTH(16), .ADDEND(1), .DROP_ON_FULL(0)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_flag(rx_flag), .rx_ack(rx_ack),
        .tx_data(tx_data), .tx_flag(tx_flag), .tx_wr(tx_wr), .mode(mode),
        .clr_ovf(clr_ovf), .count(count), .ovf(ovf)
    );

    uart_echo_fifo #(.WIDTH(8), .DEPTH(16), .ADDEND(1), .DROP_ON_FULL(1)) dut_d (
        .clk(clk), .reset(reset), .rx_data(d_rx_data), .rx_flag(d_rx_flag),
        .rx_ack(d_rx_ack), .tx_data(d_tx_data), .tx_flag(d_tx_flag), .tx_wr(d_tx_wr),
        .mode(d_mode), .clr_ovf(d_clr_ovf), .count(d_count), .ovf(d_ovf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One word through an empty FIFO with tx_flag high: ack at N+1, tx_wr at N+2
    task automatic echo(input string tag, input logic [7:0] din, input logic [1:0] m,
                        input logic [7:0] exp);
        mode    = m;
        rx_data = din;
        rx_flag = 1'b1;
        tick();
        check({tag, "_ack"}, rx_ack, 1);
        check({tag, "_early"}, tx_wr, 0);
        rx_flag = 1'b0;
        tick();
        check({tag, "_wr"}, tx_wr, 1);
        check({tag, "_data"}, tx_data, exp);
        tick();
        check({tag, "_wr_low"}, tx_wr, 0);
    endtask

    initial begin
        reset = 1'b1;
        {rx_data, rx_flag, tx_flag, mode, clr_ovf} = '0;
        {d_rx_data, d_rx_flag, d_tx_flag, d_mode, d_clr_ovf} = '0;
        tick();
        check("rst_rx_ack", rx_ack, 0);
        check("rst_tx_wr", tx_wr, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_count", count, 0);
        check("rst_ovf", ovf, 0);
        reset = 1'b0;

        tx_flag = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("idle_no_wr", tx_wr, 0);
        end

        // Basic echo with cycle-exact count
        mode    = 2'd1;
        rx_data = 8'h41;
        rx_flag = 1'b1;
        tick();
        check("echo_ack", rx_ack, 1);
        check("echo_count1", count, 1);
        rx_flag = 1'b0;
        tick();
        check("echo_ack_low", rx_ack, 0);
        check("echo_wr", tx_wr, 1);
        check("echo_data", tx_data, 8'h42);
        check("echo_count0", count, 0);
        tick();
        check("echo_wr_low", tx_wr, 0);

        echo("add_wrap", 8'hFF, 2'd1, 8'h00);
        echo("swap_a", 8'h61, 2'd3, 8'h41);
        echo("swap_Z", 8'h5A, 2'd3, 8'h7A);
        echo("swap_1", 8'h31, 2'd3, 8'h31);
        echo("swap_at", 8'h40, 2'd3, 8'h40);
        echo("swap_brace", 8'h7B, 2'd3, 8'h7B);
        echo("swap_z", 8'h7A, 2'd3, 8'h5A);
        echo("inv", 8'h0F, 2'd2, 8'hF0);
        echo("pass", 8'h5A, 2'd0, 8'h5A);

        // Fill and stall
        tx_flag = 1'b0;
        mode    = 2'd0;
        for (int i = 0; i < 16; i++) begin
            rx_data = 8'h10 + 8'(i);
            rx_flag = 1'b1;
            tick();
            check("fill_ack", rx_ack, 1);
            check("fill_count", count, i + 1);
            rx_flag = 1'b0;
            tick();
        end
        rx_data = 8'h20;
        rx_flag = 1'b1;
        tick();
        check("stall_no_ack", rx_ack, 0);
        check("stall_count", count, 16);
        tick();
        check("stall_no_ack2", rx_ack, 0);
        tx_flag = 1'b1;
        got   = 0;
        acked = 0;
        for (int c = 0; c < 200 && got < 17; c++) begin
            tick();
            if (rx_ack) begin
                acked   = 1;
                rx_flag = 1'b0;
            end
            if (tx_wr) begin
                check("stall_order", tx_data, 32'h10 + got);
                got++;
            end
        end
        check("stall_got", got, 17);
        check("stall_acked", acked, 1);
        tick();
        check("stall_ovf", ovf, 0);
        check("stall_empty", count, 0);

        // Fill and drop; the clear coincides with the drop and must lose
        for (int i = 0; i < 16; i++) begin
            d_rx_data = 8'h10 + 8'(i);
            d_rx_flag = 1'b1;
            tick();
            check("dfill_ack", d_rx_ack, 1);
            d_rx_flag = 1'b0;
            tick();
        end
        check("dfill_count", d_count, 16);
        d_rx_data = 8'h20;
        d_rx_flag = 1'b1;
        d_clr_ovf = 1'b1;
        tick();
        check("drop_ack", d_rx_ack, 1);
        check("drop_ovf_set_wins", d_ovf, 1);
        check("drop_count", d_count, 16);
        d_rx_flag = 1'b0;
        d_clr_ovf = 1'b0;
        d_tx_flag = 1'b1;
        got = 0;
        for (int c = 0; c < 200 && got < 16; c++) begin
            tick();
            if (d_tx_wr) begin
                check("drop_order", d_tx_data, 32'h10 + got);
                got++;
            end
        end
        check("drop_got", got, 16);
        extra = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (d_tx_wr) extra++;
        end
        check("drop_no_extra", extra, 0);
        check("drop_empty", d_count, 0);
        check("drop_ovf_sticky", d_ovf, 1);
        d_clr_ovf = 1'b1;
        tick();
        d_clr_ovf = 1'b0;
        check("drop_ovf_clr", d_ovf, 0);

        // Async reset mid-stream with count=5 and tx_wr high
        tx_flag = 1'b0;
        mode    = 2'd0;
        for (int i = 0; i < 6; i++) begin
            rx_data = 8'h51 + 8'(i);
            rx_flag = 1'b1;
            tick();
            rx_flag = 1'b0;
            tick();
        end
        check("ar_count6", count, 6);
        tx_flag = 1'b1;
        tick();
        check("ar_wr", tx_wr, 1);
        check("ar_count5", count, 5);
        check("ar_data", tx_data, 8'h51);
        #2 reset = 1'b1;
        #1;
        check("ar_wr_clr", tx_wr, 0);
        check("ar_count_clr", count, 0);
        check("ar_data_clr", tx_data, 0);
        check("ar_ack_clr", rx_ack, 0);
        check("ar_ovf_clr", ovf, 0);
        tick();
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            check("ar_no_wr", tx_wr, 0);
            check("ar_stay_empty", count, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
